// File: rtl/reg_access_pkg.sv
// Shared definitions for the register access sequencer.
// Holds the fetch FSM state encoding, the instruction field positions of the
// two source register indices and the default data/index widths.
package reg_access_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Source register fields inside the 32-bit instruction word
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } seq_state_e;

endpackage

// File: rtl/reg_bypass_mux.sv
// Read-after-write bypass select for one operand.
// Chooses between a write strobed in the capture cycle, a write strobed one
// cycle earlier, and the raw register-file read data, in that priority.
// Ports:
//   rd_index   index being read
//   now_we/now_reg/now_data     write strobe active in the capture cycle
//   prev_we/prev_reg/prev_data  write strobe from the cycle before capture
//   rd_data    raw register-file read data
//   sel_data   selected operand value
module reg_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rd_index,
  input  logic              now_we,
  input  logic [ADDR_W-1:0] now_reg,
  input  logic [DATA_W-1:0] now_data,
  input  logic              prev_we,
  input  logic [ADDR_W-1:0] prev_reg,
  input  logic [DATA_W-1:0] prev_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] sel_data
);

  // Priority select: newest matching write wins over older write and raw read
  always_comb begin
    sel_data = rd_data;
    if (now_we && (now_reg == rd_index) && (rd_index != {ADDR_W{1'b0}})) begin
      sel_data = now_data;
    end else if (prev_we && (prev_reg == rd_index)) begin
      sel_data = prev_data;
    end else begin
      sel_data = rd_data;
    end
  end

endmodule

// File: rtl/register_access_sequencer.sv
// Initiator side of the register-file port in the multi-cycle datapath.
// Operand fetches become two-address reads (one-cycle registered read latency
// covered by the READ/WAIT states) and are returned on a valid/ready handshake.
// Write-back requests become single-beat, one-cycle write strobes.
// Optional macro REGSEQ_BYPASS_EN adds read-after-write bypass at the capture.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   opValid/opReady/instr           operand-fetch request (rs, rt in instr)
//   operandValid/operandReady       operand return handshake
//   operandA/operandB               values of rs / rt
//   wbValid/wbReady/wbRegister/wbData  write-back request (wbReady always 1)
//   rfReadRegister1/2, rfReadData1/2   register-file read port
//   rfWriteRegister/Data/Enable        register-file write port
//   busy                            fetch FSM not idle
module register_access_sequencer
  import reg_access_pkg::*;
#(
  parameter int DATA_W           = DEFAULT_DATA_W,
  parameter int ADDR_W           = DEFAULT_ADDR_W,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              opValid,
  output logic              opReady,
  input  logic [31:0]       instr,
  output logic              operandValid,
  input  logic              operandReady,
  output logic [DATA_W-1:0] operandA,
  output logic [DATA_W-1:0] operandB,
  input  logic              wbValid,
  output logic              wbReady,
  input  logic [ADDR_W-1:0] wbRegister,
  input  logic [DATA_W-1:0] wbData,
  output logic [ADDR_W-1:0] rfReadRegister1,
  output logic [ADDR_W-1:0] rfReadRegister2,
  input  logic [DATA_W-1:0] rfReadData1,
  input  logic [DATA_W-1:0] rfReadData2,
  output logic [ADDR_W-1:0] rfWriteRegister,
  output logic [DATA_W-1:0] rfWriteData,
  output logic              rfWriteEnable,
  output logic              busy
);

  seq_state_e        state_r;
  seq_state_e        state_next_s;
  logic              op_ready_s;
  logic              accept_s;
  logic              wr_strobe_s;
  logic [ADDR_W-1:0] rs_s;
  logic [ADDR_W-1:0] rt_s;
  logic [DATA_W-1:0] capture_a_s;
  logic [DATA_W-1:0] capture_b_s;
  logic              instr_unused_s;

  assign rs_s           = ADDR_W'(instr[RS_HI:RS_LO]);
  assign rt_s           = ADDR_W'(instr[RT_HI:RT_LO]);
  assign instr_unused_s = ^{instr[31:26], instr[15:0]};

  assign accept_s = opValid && op_ready_s;
  assign opReady  = op_ready_s;
  assign wbReady  = 1'b1;
  assign busy     = (state_r != ST_IDLE);

  // A write to index 0 is accepted but never strobed when protection is on
  assign wr_strobe_s = !(ZERO_REG_PROTECT && (wbRegister == {ADDR_W{1'b0}}));

  // Request acceptance: idle, or handing off straight from HOLD as operands leave
  always_comb begin
    op_ready_s = 1'b0;
    case (state_r)
      ST_IDLE: op_ready_s = 1'b1;
      ST_HOLD: op_ready_s = operandReady;
      default: op_ready_s = 1'b0;
    endcase
  end

  // Next-state logic of the fetch FSM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_READ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_READ: state_next_s = ST_WAIT;
      ST_WAIT: state_next_s = ST_HOLD;
      ST_HOLD: begin
        if (operandReady && opValid) begin
          state_next_s = ST_READ;
        end else if (operandReady) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Fetch FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read addresses are latched on accept and held through READ/WAIT/HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfReadRegister1 <= {ADDR_W{1'b0}};
      rfReadRegister2 <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      rfReadRegister1 <= rs_s;
      rfReadRegister2 <= rt_s;
    end else begin
      rfReadRegister1 <= rfReadRegister1;
      rfReadRegister2 <= rfReadRegister2;
    end
  end

  // Operand capture at the end of WAIT; frozen in HOLD until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operandA     <= {DATA_W{1'b0}};
      operandB     <= {DATA_W{1'b0}};
      operandValid <= 1'b0;
    end else if (state_r == ST_WAIT) begin
      operandA     <= capture_a_s;
      operandB     <= capture_b_s;
      operandValid <= 1'b1;
    end else if ((state_r == ST_HOLD) && operandReady) begin
      operandValid <= 1'b0;
    end else begin
      operandValid <= operandValid;
    end
  end

  // Write-back beat: register the request and strobe for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rfWriteRegister <= {ADDR_W{1'b0}};
      rfWriteData     <= {DATA_W{1'b0}};
      rfWriteEnable   <= 1'b0;
    end else if (wbValid) begin
      rfWriteRegister <= wbRegister;
      rfWriteData     <= wbData;
      rfWriteEnable   <= wr_strobe_s;
    end else begin
      rfWriteEnable   <= 1'b0;
    end
  end

`ifdef REGSEQ_BYPASS_EN
  logic              prev_we_r;
  logic [ADDR_W-1:0] prev_reg_r;
  logic [DATA_W-1:0] prev_data_r;

  // Remember last cycle's strobe; during WAIT this is the strobe seen in READ,
  // which the register file may not have reflected in its read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_we_r   <= 1'b0;
      prev_reg_r  <= {ADDR_W{1'b0}};
      prev_data_r <= {DATA_W{1'b0}};
    end else begin
      prev_we_r   <= rfWriteEnable;
      prev_reg_r  <= rfWriteRegister;
      prev_data_r <= rfWriteData;
    end
  end

  reg_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_a (
    .rd_index  (rfReadRegister1),
    .now_we    (rfWriteEnable),
    .now_reg   (rfWriteRegister),
    .now_data  (rfWriteData),
    .prev_we   (prev_we_r),
    .prev_reg  (prev_reg_r),
    .prev_data (prev_data_r),
    .rd_data   (rfReadData1),
    .sel_data  (capture_a_s)
  );

  reg_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bypass_b (
    .rd_index  (rfReadRegister2),
    .now_we    (rfWriteEnable),
    .now_reg   (rfWriteRegister),
    .now_data  (rfWriteData),
    .prev_we   (prev_we_r),
    .prev_reg  (prev_reg_r),
    .prev_data (prev_data_r),
    .rd_data   (rfReadData2),
    .sel_data  (capture_b_s)
  );
`else
  // Raw capture: control spaces requests to avoid read-after-write hazards
  assign capture_a_s = rfReadData1;
  assign capture_b_s = rfReadData2;
`endif

endmodule

// File: tb/tb_register_access_sequencer.sv
// Bench for register_access_sequencer paired with a behavioural register file
// (registered read, synchronous reset driven from the synchronized inverse of
// rst_n). Expected operand values come from a shadow array of register
// contents updated as writes are issued.
module tb_register_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        opValid, opReady, operandValid, operandReady;
  logic [31:0] instr;
  logic [31:0] operandA, operandB;
  logic        wbValid, wbReady;
  logic [4:0]  wbRegister;
  logic [31:0] wbData;
  logic [4:0]  rfReadRegister1, rfReadRegister2, rfWriteRegister;
  logic [31:0] rfReadData1, rfReadData2, rfWriteData;
  logic        rfWriteEnable, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ref_mem [32];

  always #5 clk = ~clk;

  register_access_sequencer #(.DATA_W(32), .ADDR_W(5), .ZERO_REG_PROTECT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .opValid(opValid), .opReady(opReady), .instr(instr),
    .operandValid(operandValid), .operandReady(operandReady),
    .operandA(operandA), .operandB(operandB),
    .wbValid(wbValid), .wbReady(wbReady), .wbRegister(wbRegister), .wbData(wbData),
    .rfReadRegister1(rfReadRegister1), .rfReadRegister2(rfReadRegister2),
    .rfReadData1(rfReadData1), .rfReadData2(rfReadData2),
    .rfWriteRegister(rfWriteRegister), .rfWriteData(rfWriteData),
    .rfWriteEnable(rfWriteEnable), .busy(busy)
  );

  // Register file model
  logic [1:0]  rf_rst_sync;
  logic        rf_rst;
  logic [31:0] rf_mem [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rf_rst_sync <= 2'b11;
    else        rf_rst_sync <= {rf_rst_sync[0], 1'b0};
  end
  assign rf_rst = rf_rst_sync[1] | ~rst_n;

  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
      rfReadData1 <= 32'd0;
      rfReadData2 <= 32'd0;
    end else begin
      if (rfWriteEnable) rf_mem[rfWriteRegister] <= rfWriteData;
      rfReadData1 <= rf_mem[rfReadRegister1];
      rfReadData2 <= rf_mem[rfReadRegister2];
    end
  end

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } fetch_vec_t;

  fetch_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
  endtask

  // One write-back beat; leaves wbValid high for a possible next beat
  task automatic write_beat(input logic [4:0] r, input logic [31:0] d);
    wbValid = 1'b1;
    wbRegister = r;
    wbData = d;
    step();
    check("wr_enable", {31'd0, rfWriteEnable}, {31'd0, (r != 5'd0)});
    if (r != 5'd0) begin
      check("wr_reg", {27'd0, rfWriteRegister}, {27'd0, r});
      check("wr_data", rfWriteData, d);
      ref_mem[r] = d;
    end
  endtask

  // Full fetch from idle: accept, latency check, optional hold, release
  task automatic fetch(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input int hold, output logic [31:0] a, output logic [31:0] b);
    int edges;
    instr = {6'd0, rs, rt, 16'h5A5A};
    opValid = 1'b1;
    #1;
    check({tag, "_op_ready"}, {31'd0, opReady}, 32'd1);
    step();
    opValid = 1'b0;
    edges = 1;
    while (!operandValid && edges < 10) begin
      step();
      edges++;
    end
    check({tag, "_latency"}, edges, 32'd3);
    a = operandA;
    b = operandB;
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_a"}, operandA, a);
      check({tag, "_hold_valid"}, {31'd0, operandValid}, 32'd1);
    end
    operandReady = 1'b1;
    step();
    operandReady = 1'b0;
    check({tag, "_valid_clr"}, {31'd0, operandValid}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, held_a, exp_a, exp_b;
    logic [4:0]  rs, rt, wr;
    int nw;

    rst_n = 1'b0;
    opValid = 1'b0; operandReady = 1'b0; instr = 32'd0;
    wbValid = 1'b0; wbRegister = 5'd0; wbData = 32'd0;
    clear_ref();

    // Reset state
    repeat (3) step();
    check("rst_op_ready", {31'd0, opReady}, 32'd1);
    check("rst_wb_ready", {31'd0, wbReady}, 32'd1);
    check("rst_op_valid", {31'd0, operandValid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_we", {31'd0, rfWriteEnable}, 32'd0);
    check("rst_rd_reg1", {27'd0, rfReadRegister1}, 32'd0);
    check("rst_operand_a", operandA, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // 1: write r5, fetch (5,0)
    write_beat(5'd5, 32'hDEADBEEF);
    wbValid = 1'b0;
    step(); step();
    fetch("t1", 5'd5, 5'd0, 0, a, b);
    check("t1_a", a, 32'hDEADBEEF);
    check("t1_b", b, 32'd0);

    // 2: protected write to r0
    write_beat(5'd0, 32'h1234);
    wbValid = 1'b0;
    step();
    check("t2_we_after", {31'd0, rfWriteEnable}, 32'd0);
    step();
    fetch("t2", 5'd0, 5'd0, 0, a, b);
    check("t2_a", a, 32'd0);
    check("t2_b", b, 32'd0);

    // 3: writes to r7 during READ and WAIT of a fetch of r7
    write_beat(5'd7, 32'h11);
    wbValid = 1'b0;
    step(); step();
    instr = {6'd0, 5'd7, 5'd3, 16'd0};
    opValid = 1'b1;
    wbValid = 1'b1; wbRegister = 5'd7; wbData = 32'h22;
    step();                             // accept edge
    opValid = 1'b0;
    wbData = 32'h33;
    step();                             // end of READ
    wbValid = 1'b0;
    check("t3_we_wait", {31'd0, rfWriteEnable}, 32'd1);
    step();                             // end of WAIT
    check("t3_valid", {31'd0, operandValid}, 32'd1);
`ifdef REGSEQ_BYPASS_EN
    check("t3_a", operandA, 32'h33);
`else
    check("t3_a", operandA, 32'h11);
`endif
    check("t3_b", operandB, 32'd0);
    ref_mem[7] = 32'h33;

    // 4: hold with operandReady low while r7 is rewritten, then handoff
    held_a = operandA;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) write_beat(5'd7, 32'h44);
      else        step();
      wbValid = 1'b0;
      #1;
      check("t4_hold_a", operandA, held_a);
      check("t4_hold_valid", {31'd0, operandValid}, 32'd1);
      check("t4_op_ready_low", {31'd0, opReady}, 32'd0);
    end
    operandReady = 1'b1;
    opValid = 1'b1;
    instr = {6'd0, 5'd7, 5'd5, 16'd0};
    #1;
    check("t4_handoff_ready", {31'd0, opReady}, 32'd1);
    step();                             // handoff accept edge
    operandReady = 1'b0;
    opValid = 1'b0;
    check("t4_valid_drop", {31'd0, operandValid}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd1);
    step();
    check("t4_not_yet", {31'd0, operandValid}, 32'd0);
    step();
    check("t4_valid3", {31'd0, operandValid}, 32'd1);
    check("t4_a", operandA, 32'h44);
    check("t4_b", operandB, 32'hDEADBEEF);
    operandReady = 1'b1;
    step();
    operandReady = 1'b0;
    check("t4_idle", {31'd0, busy}, 32'd0);

    // 5: reset during WAIT with a write strobe pending
    instr = {6'd0, 5'd9, 5'd9, 16'd0};
    opValid = 1'b1;
    step();
    opValid = 1'b0;
    wbValid = 1'b1; wbRegister = 5'd9; wbData = 32'hCAFE;
    step();
    wbValid = 1'b0;
    check("t5_we_pre", {31'd0, rfWriteEnable}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_we", {31'd0, rfWriteEnable}, 32'd0);
    check("t5_valid", {31'd0, operandValid}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_op_ready", {31'd0, opReady}, 32'd1);
    check("t5_wr_reg", {27'd0, rfWriteRegister}, 32'd0);
    check("t5_wr_data", rfWriteData, 32'd0);
    check("t5_rd_reg1", {27'd0, rfReadRegister1}, 32'd0);
    clear_ref();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    fetch("t5", 5'd9, 5'd9, 0, a, b);
    check("t5_a", a, 32'd0);
    check("t5_b", b, 32'd0);

    // 6: back-to-back writes r1..r8, then table-driven fetches
    for (int i = 1; i <= 8; i++) write_beat(5'(i), 32'(i * 16));
    wbValid = 1'b0;
    step(); step();
    vecs[0] = '{rs: 5'd1, rt: 5'd8, exp_a: 32'h10, exp_b: 32'h80};
    vecs[1] = '{rs: 5'd2, rt: 5'd7, exp_a: 32'h20, exp_b: 32'h70};
    vecs[2] = '{rs: 5'd8, rt: 5'd1, exp_a: 32'h80, exp_b: 32'h10};
    vecs[3] = '{rs: 5'd0, rt: 5'd4, exp_a: 32'h00, exp_b: 32'h40};
    for (int v = 0; v < 4; v++) begin
      fetch("t6", vecs[v].rs, vecs[v].rt, v, a, b);
      check("t6_a", a, vecs[v].exp_a);
      check("t6_b", b, vecs[v].exp_b);
    end

    // Randomized writes and fetches against the shadow register array
    for (int it = 0; it < 25; it++) begin
      nw = int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) begin
        wr = 5'($urandom_range(0, 31));
        write_beat(wr, $urandom);
      end
      wbValid = 1'b0;
      step(); step();
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      exp_a = ref_mem[rs];
      exp_b = ref_mem[rt];
      fetch("rnd", rs, rt, int'($urandom_range(0, 3)), a, b);
      check("rnd_a", a, exp_a);
      check("rnd_b", b, exp_b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
